// File: rtl/seq_detector_moore_param.sv
// ---------------------------------------------------------------------------
// seq_detector_moore_param
//
// Moore serial-pattern detector with a runtime-programmable LEN-bit pattern.
// It supports overlapping and non-overlapping matching. Serial input is
// qualified by in_valid.
//
// Parameters
//   LEN    pattern length in bits (2..32)
//   CNT_W  match counter width (only with SEQDET_CNT_EN)
//
// Ports
//   clk          clock, all state on the rising edge
//   reset        synchronous active-high reset
//   cfg_load     one-cycle strobe: capture pattern/overlap, restart search
//   cfg_pattern  pattern; bit [LEN-1] is received first, bit [0] last
//   cfg_overlap  1 = overlapping matches, 0 = non-overlapping
//   in_valid     qualifies in
//   in           serial data bit
//   out          high while the FSM is in MATCH
//   armed        high while a pattern is loaded (HUNT or MATCH)
//   cnt_clr      (SEQDET_CNT_EN) synchronous clear of match_count
//   match_count  (SEQDET_CNT_EN) saturating count of match events
//
// Optional feature macro: SEQDET_CNT_EN adds the match counter and its ports.
// ---------------------------------------------------------------------------
module seq_detector_moore_param #(
  parameter int LEN   = 3,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cfg_load,
  input  logic [LEN-1:0]   cfg_pattern,
  input  logic             cfg_overlap,
  input  logic             in_valid,
  input  logic             in,
`ifdef SEQDET_CNT_EN
  input  logic             cnt_clr,
  output logic [CNT_W-1:0] match_count,
`endif
  output logic             out,
  output logic             armed
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] HUNT  = 2'd1;
  localparam logic [1:0] MATCH = 2'd2;

  localparam int FW = $clog2(LEN + 1);

  logic [1:0]     state_q, state_d;
  logic [LEN-1:0] pat_q, pat_d;
  logic           ovl_q, ovl_d;
  // Only the newest LEN-1 bits are stored. The oldest bit of a full window
  // is never needed again because the next shift pushes it out.
  logic [LEN-2:0] hist_q, hist_d;
  logic [FW-1:0]  fill_q, fill_d;

  logic           active;
  logic           accept;
  logic           hit;
  logic [LEN-1:0] hist_n;
  logic [FW-1:0]  fill_n;

  assign active = (state_q == HUNT) || (state_q == MATCH);
  // A load on the same edge discards any simultaneous data bit.
  assign accept = active && !cfg_load && in_valid;
  assign hist_n = {hist_q, in};
  assign fill_n = (fill_q == FW'(LEN)) ? fill_q : fill_q + FW'(1);
  assign hit    = accept && (fill_n == FW'(LEN)) && (hist_n == pat_q);

  always_comb begin
    state_d = state_q;
    pat_d   = pat_q;
    ovl_d   = ovl_q;
    hist_d  = hist_q;
    fill_d  = fill_q;
    case (state_q)
      IDLE, HUNT, MATCH: begin
        if (cfg_load) begin
          state_d = HUNT;
          pat_d   = cfg_pattern;
          ovl_d   = cfg_overlap;
          hist_d  = '0;
          fill_d  = '0;
        end else if (accept) begin
          if (hit) begin
            state_d = MATCH;
            if (ovl_q) begin
              hist_d = hist_n[LEN-2:0];
              fill_d = fill_n;
            end else begin
              // Non-overlapping: the next match must be built from fresh bits.
              hist_d = '0;
              fill_d = '0;
            end
          end else begin
            state_d = HUNT;
            hist_d  = hist_n[LEN-2:0];
            fill_d  = fill_n;
          end
        end
      end
      default: begin
        state_d = IDLE;
        hist_d  = '0;
        fill_d  = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      pat_q   <= '0;
      ovl_q   <= 1'b0;
      hist_q  <= '0;
      fill_q  <= '0;
    end else begin
      state_q <= state_d;
      pat_q   <= pat_d;
      ovl_q   <= ovl_d;
      hist_q  <= hist_d;
      fill_q  <= fill_d;
    end
  end

  assign out   = (state_q == MATCH);
  assign armed = active;

`ifdef SEQDET_CNT_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // A clear wins over a simultaneous increment. The count saturates at all-ones.
  always_comb begin
    cnt_d = cnt_q;
    if (cnt_clr) begin
      cnt_d = '0;
    end else if (hit && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign match_count = cnt_q;
`endif

endmodule

// File: tb/tb_seq_detector_moore_param.sv
// ---------------------------------------------------------------------------
// Testbench for seq_detector_moore_param (LEN=3).
//
// The driver issues one input vector per clock. Each vector carries a
// hand-computed expected {out, armed, match_count}, which is pushed into a
// queue. A monitor pops one entry on each falling edge and compares it with
// the DUT outputs. The counter is checked only when SEQDET_CNT_EN is defined,
// and then with CNT_W=2 so that saturation is reached.
// ---------------------------------------------------------------------------
module tb_seq_detector_moore_param;

  localparam int LEN = 3;
`ifdef SEQDET_CNT_EN
  localparam int CNT_W = 2;
`else
  localparam int CNT_W = 8;
`endif

  typedef struct packed {
    logic             o;
    logic             a;
    logic             clr;
    logic [CNT_W-1:0] c;
  } exp_t;

  logic           clk;
  logic           reset;
  logic           cfg_load;
  logic [LEN-1:0] cfg_pattern;
  logic           cfg_overlap;
  logic           in_valid;
  logic           in;
  logic           out;
  logic           armed;
`ifdef SEQDET_CNT_EN
  logic             cnt_clr;
  logic [CNT_W-1:0] match_count;
`endif

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   txn    = 0;

  seq_detector_moore_param #(.LEN(LEN), .CNT_W(CNT_W)) dut (
    .clk         (clk),
    .reset       (reset),
    .cfg_load    (cfg_load),
    .cfg_pattern (cfg_pattern),
    .cfg_overlap (cfg_overlap),
    .in_valid    (in_valid),
    .in          (in),
`ifdef SEQDET_CNT_EN
    .cnt_clr     (cnt_clr),
    .match_count (match_count),
`endif
    .out         (out),
    .armed       (armed)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Monitor: one comparison per issued vector, sampled on the falling edge.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      logic ok;
      e  = exp_q.pop_front();
      ok = (out === e.o) && (armed === e.a);
`ifdef SEQDET_CNT_EN
      ok = ok && (match_count === e.c);
      if (!ok)
        $display("FAIL txn%0d got out=%b armed=%b cnt=%0d want out=%b armed=%b cnt=%0d",
                 txn, out, armed, match_count, e.o, e.a, e.c);
`else
      if (!ok)
        $display("FAIL txn%0d got out=%b armed=%b want out=%b armed=%b",
                 txn, out, armed, e.o, e.a);
`endif
      checks = checks + 1;
      if (!ok) errors = errors + 1;
      else $display("txn%0d out=%b armed=%b clr=%b cnt=%0d ok", txn, e.o, e.a, e.clr, e.c);
      txn = txn + 1;
    end
  end

  // Drive one cycle of stimulus and queue the response expected after that edge.
  task automatic step(input logic rst, input logic ld, input logic [LEN-1:0] pat,
                      input logic ovl, input logic v, input logic b, input logic clr,
                      input logic eo, input logic ea, input int ec);
    exp_t e;
    reset       = rst;
    cfg_load    = ld;
    cfg_pattern = pat;
    cfg_overlap = ovl;
    in_valid    = v;
    in          = b;
`ifdef SEQDET_CNT_EN
    cnt_clr     = clr;
`endif
    @(posedge clk);
    e.o   = eo;
    e.a   = ea;
    e.clr = clr;
    e.c   = CNT_W'(ec);
    exp_q.push_back(e);
    #1;
  endtask

  // One accepted data bit, with no load and no clear.
  task automatic bit_in(input logic b, input logic eo, input int ec);
    step(1'b0, 1'b0, 3'b000, 1'b0, 1'b1, b, 1'b0, eo, 1'b1, ec);
  endtask

  initial begin
    int wait_cyc;
    reset = 1'b1; cfg_load = 1'b0; cfg_pattern = '0; cfg_overlap = 1'b0;
    in_valid = 1'b0; in = 1'b0;
`ifdef SEQDET_CNT_EN
    cnt_clr = 1'b0;
`endif

    // Reset state.
    step(1, 0, 3'b000, 0, 0, 0, 0, 0, 0, 0);
    step(1, 0, 3'b000, 0, 1, 1, 0, 0, 0, 0);

    // 1: valid bits without a load are ignored in IDLE.
    step(0, 0, 3'b000, 0, 1, 0, 0, 0, 0, 0);
    step(0, 0, 3'b000, 0, 1, 1, 0, 0, 0, 0);
    step(0, 0, 3'b000, 0, 1, 0, 0, 0, 0, 0);
    step(0, 0, 3'b000, 0, 1, 1, 0, 0, 0, 0);

    // 2: pattern 010 with overlap; stream 0,1,0,1,0,0,1,0.
    step(0, 1, 3'b010, 1, 0, 0, 0, 0, 1, 0);
    bit_in(0, 0, 0); bit_in(1, 0, 0); bit_in(0, 1, 1); bit_in(1, 0, 1);
    bit_in(0, 1, 2); bit_in(0, 0, 2); bit_in(1, 0, 2); bit_in(0, 1, 3);

    // 4: MATCH holds through idle cycles, then drops on the next accepted bit.
    for (int i = 0; i < 5; i++) step(0, 0, 3'b000, 0, 0, 1, 0, 1, 1, 3);
    bit_in(1, 0, 3);

    // 3: same stream without overlap (the counter is cleared with the load).
    step(0, 1, 3'b010, 0, 0, 0, 1, 0, 1, 0);
    bit_in(0, 0, 0); bit_in(1, 0, 0); bit_in(0, 1, 1); bit_in(1, 0, 1);
    bit_in(0, 0, 1); bit_in(0, 0, 1); bit_in(1, 0, 1); bit_in(0, 1, 2);

    // 5: a load clears history and drops the bit presented with it.
    step(0, 1, 3'b010, 1, 0, 0, 0, 0, 1, 2);
    bit_in(0, 0, 2); bit_in(1, 0, 2);
    step(0, 1, 3'b010, 1, 1, 0, 0, 0, 1, 2);
    bit_in(0, 0, 2); bit_in(1, 0, 2); bit_in(0, 1, 3);
    step(0, 1, 3'b010, 1, 1, 0, 0, 0, 1, 3);
    bit_in(1, 0, 3); bit_in(0, 0, 3);

    // 6: five matches saturate a 2-bit counter; then clear it, alone and on a match edge.
    step(0, 0, 3'b000, 0, 0, 0, 1, 0, 1, 0);
    step(0, 1, 3'b010, 1, 0, 0, 0, 0, 1, 0);
    bit_in(0, 0, 0); bit_in(1, 0, 0); bit_in(0, 1, 1); bit_in(1, 0, 1);
    bit_in(0, 1, 2); bit_in(1, 0, 2); bit_in(0, 1, 3); bit_in(1, 0, 3);
    bit_in(0, 1, 3); bit_in(1, 0, 3); bit_in(0, 1, 3);
    step(0, 0, 3'b000, 0, 0, 0, 1, 1, 1, 0);
    bit_in(1, 0, 0);
    step(0, 0, 3'b000, 0, 1, 0, 1, 1, 1, 0);
    bit_in(1, 0, 0); bit_in(0, 1, 1);

    // A reset while in MATCH returns the FSM to IDLE; IDLE then ignores data.
    step(1, 0, 3'b000, 0, 1, 1, 0, 0, 0, 0);
    step(0, 0, 3'b000, 0, 1, 0, 0, 0, 0, 0);

    in_valid = 1'b0;
    wait_cyc = 0;
    while (exp_q.size() > 0 && wait_cyc < 10) begin
      @(posedge clk);
      wait_cyc++;
    end
    if (exp_q.size() > 0) begin
      $display("FAIL drain got %0d pending want 0", exp_q.size());
      errors = errors + 1;
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
